cache_data_responder: RTL and testbench
=======================================

# cache_data_responder

EBOX-side cache data responder: the memory end of the EDP cache data path. It accepts single-word read/write requests from the EBOX and captures the EDP's outgoing `cacheDataWrite` word on writes. After a fixed, parameterised latency it returns the addressed word on `cacheDataRead` with a one-cycle acknowledge. It stands in for the MBOX cache data path during EDP/EBOX bring-up and lets EBOX microcode sequences run against real storage.

## Interface

Parameters:
- `ADR_BITS`, 9: word address width; the backing store holds 2^ADR_BITS 36-bit words.
- `WAIT_CYCLES`, 2: extra wait states between request acceptance and acknowledge (0..15).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `eboxClk`, input, 1: EBOX clock; all state changes on its posedge.
  - `eboxReset_L`, input, 1: asynchronous active-low reset.
- Request side:
  - `memReq`, input, 1: request strobe, sampled only in IDLE.
  - `memWrite`, input, 1: 1 = write, 0 = read; qualified by `memReq`.
  - `memAdr`, input, [0:ADR_BITS-1]: word address; bit 0 is the MSB.
  - `cacheDataWrite`, input, [0:35]: write word from the EDP, captured at acceptance.
- Response side:
  - `cacheDataRead`, output, [0:35]: read data to the EDP; holds its value between reads.
  - `memAck`, output, 1: one-cycle completion pulse, for reads and writes.
  - `memBusy`, output, 1: high from the cycle after acceptance through the ACK cycle.
  - `memParityErr`, output, 1: read parity error flag; see Configuration.

## Operation

- States: IDLE, WAIT, ACK. Encoding is free.
- IDLE:
  - On a posedge with `memReq`=1: latch `memAdr`, `memWrite` and `cacheDataWrite`, and load the wait counter with `WAIT_CYCLES`.
  - Next state is WAIT if `WAIT_CYCLES`>0, else ACK.
- WAIT:
  - Decrement the counter each cycle.
  - On the posedge where the counter is 1, go to ACK.
- Entering ACK, at the same posedge:
  - Write: store the latched data at the latched address. `cacheDataRead` is unchanged.
  - Read: load `cacheDataRead` from the store at the latched address.
- ACK: `memAck`=1 for exactly one cycle, then unconditionally IDLE.
  - A `memReq` present during the ACK cycle is ignored. The requester must hold or re-assert it in IDLE.
- `memReq` in WAIT/ACK is ignored; requests are not queued.
- Input changes after acceptance have no effect on the operation in flight.
- Read-after-write to the same address returns the new word.
- Address wrap does not occur; addresses beyond 2^ADR_BITS are impossible by width.
- Backing store:
  - Synchronous single-port array.
  - Not cleared by reset; contents are X until written.

## Timing

- Reset values:
  - state IDLE, counter 0;
  - `cacheDataRead`=36'h0;
  - `memAck`=0, `memBusy`=0, `memParityErr`=0.
- Reset asserted mid-operation:
  - Aborts immediately.
  - A pending write is not committed.
  - No `memAck` is produced.
- Latency: request accepted at edge N; `memAck` is high in cycle N+1+`WAIT_CYCLES`.
  - With `WAIT_CYCLES`=0, `memAck` is high the cycle after acceptance.
- Throughput: one request per `WAIT_CYCLES`+2 cycles at best. The earliest next acceptance is the first posedge after the ACK cycle.
- `cacheDataRead` is valid from the ACK cycle until the next read's ACK.

## Configuration

- Macro `CACHE_PARITY_EN`.
- Defined:
  - The store is 37 bits wide; bit 36 holds odd parity over bits 0..35, generated at write commit.
  - On a read, `memParityErr` is set in the ACK cycle, alongside `memAck`, when the stored word plus its parity bit has even weight. It is cleared on the next cycle.
  - Bench hook: `memWrite` with `memAdr` all-ones and `cacheDataWrite`=36'hFFFFFFFFF stores inverted parity.
- Not defined:
  - The store is 36 bits wide and no parity logic exists.
  - `memParityErr` is tied to 0.

## Test plan

- Reset then idle: `eboxReset_L`=0 for 2 cycles, then 1 with no requests → `cacheDataRead`=0, `memAck`=0, `memBusy`=0 throughout.
- Write then read: write 36'h123456789 at address 9'h007, then read address 9'h007 (`WAIT_CYCLES`=2) → `memAck` three cycles after each acceptance; read returns 36'h123456789.
- Back-to-back:
  - Write 36'h987654321 at 9'h010, then read 9'h010, with `memReq` held high continuously → second acceptance occurs in the first cycle after ACK.
  - Read returns 36'h987654321.
  - `memReq` during WAIT and ACK does not cause extra acks.
- Write does not disturb read data: read 9'h007 (36'h123456789), then write 36'h0 to 9'h020 → `cacheDataRead` stays 36'h123456789 through the write's ACK.
- Reset mid-write: accept a write of 36'hABCDEF012 to 9'h007, then pulse `eboxReset_L` low in WAIT → no `memAck`; a subsequent read of 9'h007 returns 36'h123456789.
- With `CACHE_PARITY_EN`:
  - Write 36'hFFFFFFFFF to 9'h1FF, then read it → `memParityErr`=1 in the ACK cycle.
  - Read 9'h007 → `memParityErr`=0.

Source files
------------

// File: rtl/cache_data_responder_if.sv
// EBOX <-> cache data responder request/response bundle.
// The master modport is the EBOX/EDP side; the slave modport is the responder.
interface cache_data_responder_if #(
  parameter int ADR_BITS = 9
);
  logic                memReq;
  logic                memWrite;
  logic [0:ADR_BITS-1] memAdr;
  logic [0:35]         cacheDataWrite;
  logic [0:35]         cacheDataRead;
  logic                memAck;
  logic                memBusy;
  logic                memParityErr;

  modport master (
    output memReq, memWrite, memAdr, cacheDataWrite,
    input  cacheDataRead, memAck, memBusy, memParityErr
  );

  modport slave (
    input  memReq, memWrite, memAdr, cacheDataWrite,
    output cacheDataRead, memAck, memBusy, memParityErr
  );
endinterface

// File: rtl/cache_data_responder.sv
// Memory end of the EDP cache data path: one word per request, fixed latency.
// Optional odd-parity store and read check under `CACHE_PARITY_EN.
module cache_data_responder #(
  parameter int ADR_BITS    = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   eboxClk,
  input  logic                   eboxReset_L,
  cache_data_responder_if.slave  bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
`ifdef CACHE_PARITY_EN
  localparam int MEM_W = 37;
`else
  localparam int MEM_W = 36;
`endif

  logic [1:0]          state;
  logic [3:0]          cnt;
  logic                wr_q;
  logic [0:ADR_BITS-1] adr_q;
  logic [0:35]         data_q;
  logic [0:35]         rd_q;
  logic [0:MEM_W-1]    mem [0:(1<<ADR_BITS)-1];

  logic                accept, commit, c_wr;
  logic [0:ADR_BITS-1] c_adr;
  logic [0:35]         c_data;
  logic [0:MEM_W-1]    wr_word;

  assign accept = (state == S_IDLE) && bus.memReq;
  assign commit = (accept && (WAIT_LD == 4'd0)) || ((state == S_WAIT) && (cnt == 4'd1));

  // With zero wait states the commit edge is the acceptance edge, so use the live request.
  assign c_wr   = (state == S_IDLE) ? bus.memWrite       : wr_q;
  assign c_adr  = (state == S_IDLE) ? bus.memAdr         : adr_q;
  assign c_data = (state == S_IDLE) ? bus.cacheDataWrite : data_q;

`ifdef CACHE_PARITY_EN
  logic poison;
  logic perr_q;
  // All-ones word to the all-ones address stores bad parity so the checker can be exercised.
  assign poison  = c_wr && (&c_adr) && (&c_data);
  assign wr_word = {c_data, poison ? (^c_data) : ~(^c_data)};

  always_ff @(posedge eboxClk or negedge eboxReset_L)
    if (!eboxReset_L) perr_q <= 1'b0;
    else              perr_q <= commit && !c_wr && ~(^mem[c_adr]);

  assign bus.memParityErr = perr_q;
`else
  assign wr_word          = c_data;
  assign bus.memParityErr = 1'b0;
`endif

  always_ff @(posedge eboxClk)
    if (commit && c_wr) mem[c_adr] <= wr_word;

  always_ff @(posedge eboxClk or negedge eboxReset_L) begin
    if (!eboxReset_L) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      wr_q   <= 1'b0;
      adr_q  <= '0;
      data_q <= '0;
      rd_q   <= '0;
    end else begin
      if (commit && !c_wr) rd_q <= mem[c_adr][0:35];
      case (state)
        S_IDLE: if (bus.memReq) begin
          wr_q   <= bus.memWrite;
          adr_q  <= bus.memAdr;
          data_q <= bus.cacheDataWrite;
          cnt    <= WAIT_LD;
          state  <= (WAIT_LD == 4'd0) ? S_ACK : S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= S_ACK;
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cacheDataRead = rd_q;
  assign bus.memAck        = (state == S_ACK);
  assign bus.memBusy       = (state != S_IDLE);
endmodule

// File: tb/tb_cache_data_responder.sv
// Randomized self-checking bench for cache_data_responder against a word-array model.
module tb_cache_data_responder;
  localparam int W = 2;
`ifdef CACHE_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic eboxClk = 1'b0;
  logic eboxReset_L = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [0:35] mem_m [0:511];
  bit          vld_m [0:511];
  bit          poi_m [0:511];
  logic [0:35] last_rd = '0;

  cache_data_responder_if #(.ADR_BITS(9)) bus ();

  cache_data_responder #(.ADR_BITS(9), .WAIT_CYCLES(W)) dut (
    .eboxClk     (eboxClk),
    .eboxReset_L (eboxReset_L),
    .bus         (bus)
  );

  always #5 eboxClk = ~eboxClk;

  task automatic scramble();
    bus.memWrite       = 1'($urandom);
    bus.memAdr         = 9'($urandom);
    bus.cacheDataWrite = {4'($urandom), 32'($urandom)};
  endtask

  // One request; checks latency, busy, one-cycle ack, read data, held data and parity flag.
  task automatic do_op(input bit wr, input logic [0:8] a, input logic [0:35] d);
    bit seen;
    bit exp_pe;
    seen = 0;
    exp_pe = PAR && !wr && poi_m[a];
    @(negedge eboxClk);
    bus.memReq = 1'b1; bus.memWrite = wr; bus.memAdr = a; bus.cacheDataWrite = d;
    @(posedge eboxClk); #1;
    bus.memReq = 1'($urandom); scramble();
    for (int k = 1; k <= W + 4 && !seen; k++) begin
      @(negedge eboxClk);
      if (bus.memAck) begin
        seen = 1;
        checks++;
        if (k != W + 1) begin errors++; $display("FAIL latency got %0d exp %0d", k, W + 1); end
        checks++;
        if (wr) begin
          if (bus.cacheDataRead !== last_rd) begin errors++; $display("FAIL wr_hold got %h exp %h", bus.cacheDataRead, last_rd); end
        end else if (vld_m[a]) begin
          if (bus.cacheDataRead !== mem_m[a]) begin errors++; $display("FAIL rd_data adr %h got %h exp %h", a, bus.cacheDataRead, mem_m[a]); end
        end
        checks++;
        if (bus.memParityErr !== exp_pe) begin errors++; $display("FAIL perr adr %h got %b exp %b", a, bus.memParityErr, exp_pe); end
      end else begin
        checks++;
        if (bus.memBusy !== 1'b1) begin errors++; $display("FAIL busy k=%0d got %b exp 1", k, bus.memBusy); end
      end
      bus.memReq = seen ? 1'b0 : 1'($urandom); scramble();
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL ack_timeout got none exp ack at %0d", W + 1); end
    @(negedge eboxClk);
    checks++;
    if (bus.memAck !== 1'b0 || bus.memBusy !== 1'b0 || bus.memParityErr !== 1'b0) begin
      errors++; $display("FAIL ack_pulse got ack=%b busy=%b perr=%b exp 0 0 0", bus.memAck, bus.memBusy, bus.memParityErr);
    end
    if (wr) begin
      mem_m[a] = d; vld_m[a] = 1; poi_m[a] = (&a) && (&d);
    end else begin
      last_rd = mem_m[a];
    end
  endtask

  task automatic test_reset();
    bus.memReq = 1'b0; scramble();
    eboxReset_L = 1'b0;
    repeat (2) begin
      @(negedge eboxClk);
      checks++;
      if (bus.cacheDataRead !== 36'h0 || bus.memAck !== 1'b0 || bus.memBusy !== 1'b0 || bus.memParityErr !== 1'b0) begin
        errors++; $display("FAIL reset_hold got rd=%h ack=%b busy=%b exp 0", bus.cacheDataRead, bus.memAck, bus.memBusy);
      end
    end
    eboxReset_L = 1'b1;
    repeat (4) begin
      @(negedge eboxClk);
      checks++;
      if (bus.cacheDataRead !== 36'h0 || bus.memAck !== 1'b0 || bus.memBusy !== 1'b0 || bus.memParityErr !== 1'b0) begin
        errors++; $display("FAIL reset_idle got rd=%h ack=%b busy=%b exp 0", bus.cacheDataRead, bus.memAck, bus.memBusy);
      end
    end
    last_rd = '0;
  endtask

  task automatic test_write_read();
    do_op(1'b1, 9'h007, 36'h123456789);
    do_op(1'b0, 9'h007, 36'h0);
  endtask

  task automatic test_back_to_back();
    int acks;
    acks = 0;
    @(negedge eboxClk);
    bus.memReq = 1'b1; bus.memWrite = 1'b1; bus.memAdr = 9'h010; bus.cacheDataWrite = 36'h987654321;
    @(posedge eboxClk); #1;
    bus.memWrite = 1'b0;
    for (int k = 1; k <= 2 * W + 6; k++) begin
      @(negedge eboxClk);
      if (bus.memAck) begin
        acks++;
        checks++;
        if (k != W + 1 && k != 2 * W + 3) begin errors++; $display("FAIL b2b_ack_pos got %0d exp %0d or %0d", k, W + 1, 2 * W + 3); end
      end
      if (k == W + 2) begin
        checks++;
        if (bus.memBusy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b exp 0", bus.memBusy); end
      end
      if (k == W + 3) begin
        checks++;
        if (bus.memBusy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b exp 1", bus.memBusy); end
        bus.memReq = 1'b0;
      end
      if (k == 2 * W + 3) begin
        checks++;
        if (bus.cacheDataRead !== 36'h987654321) begin errors++; $display("FAIL b2b_data got %h exp %h", bus.cacheDataRead, 36'h987654321); end
      end
    end
    checks++;
    if (acks != 2) begin errors++; $display("FAIL b2b_ack_count got %0d exp 2", acks); end
    mem_m[9'h010] = 36'h987654321; vld_m[9'h010] = 1; poi_m[9'h010] = 0;
    last_rd = 36'h987654321;
  endtask

  task automatic test_write_keeps_read();
    do_op(1'b0, 9'h007, 36'h0);
    do_op(1'b1, 9'h020, 36'h0);
    checks++;
    if (bus.cacheDataRead !== 36'h123456789) begin errors++; $display("FAIL keep_read got %h exp %h", bus.cacheDataRead, 36'h123456789); end
  endtask

  task automatic test_reset_mid_write();
    @(negedge eboxClk);
    bus.memReq = 1'b1; bus.memWrite = 1'b1; bus.memAdr = 9'h007; bus.cacheDataWrite = 36'hABCDEF012;
    @(posedge eboxClk); #1;
    bus.memReq = 1'b0;
    @(negedge eboxClk);
    eboxReset_L = 1'b0;
    #1;
    checks++;
    if (bus.memBusy !== 1'b0 || bus.memAck !== 1'b0) begin errors++; $display("FAIL rst_abort got busy=%b ack=%b exp 0 0", bus.memBusy, bus.memAck); end
    @(negedge eboxClk);
    eboxReset_L = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge eboxClk);
      checks++;
      if (bus.memAck !== 1'b0) begin errors++; $display("FAIL rst_no_ack got %b exp 0", bus.memAck); end
    end
    last_rd = '0;
    do_op(1'b0, 9'h007, 36'h0);
  endtask

  task automatic test_parity();
    do_op(1'b1, 9'h1FF, 36'hFFFFFFFFF);
    do_op(1'b0, 9'h1FF, 36'h0);
    do_op(1'b0, 9'h007, 36'h0);
  endtask

  task automatic test_random();
    logic [0:8] pool [0:7];
    logic [0:8] a;
    bit wr;
    for (int i = 0; i < 8; i++) pool[i] = 9'($urandom_range(64, 400));
    for (int i = 0; i < 40; i++) begin
      a  = pool[$urandom_range(0, 7)];
      wr = !vld_m[a] || ($urandom_range(0, 2) == 0);
      do_op(wr, a, {4'($urandom), 32'($urandom)});
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) begin vld_m[i] = 0; poi_m[i] = 0; mem_m[i] = '0; end
    bus.memReq = 1'b0;
    scramble();
    test_reset();
    test_write_read();
    test_back_to_back();
    test_write_keeps_read();
    test_reset_mid_write();
    test_parity();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
